// File: rtl/shake_ctrl_if.sv
// shake_ctrl_if: handshake and strobe bundle between the SHAKE sequencer and its datapath/host
// Ports (signals):
//   start, in_len, out_len       job request from host
//   din_valid/din_ready          input word stream handshake
//   absorb_en, last_bits         absorb strobe and valid bits of current input word
//   pad_en, pad_pos              padding strobe and first pad byte offset
//   perm_start/perm_done         permutation engine request/completion
//   dout_valid/dout_ready        squeezed word handshake, dout_last marks final word
//   word_idx                     current lane within block
//   busy, done                   job status
// master: the sequencer (shake_ctrl); slave: host/datapath side
interface shake_ctrl_if #(
    parameter int LEN_WIDTH = 32
);
    logic                 start;
    logic [LEN_WIDTH-1:0] in_len;
    logic [LEN_WIDTH-1:0] out_len;
    logic                 din_valid;
    logic                 din_ready;
    logic                 absorb_en;
    logic [6:0]           last_bits;
    logic                 pad_en;
    logic [10:0]          pad_pos;
    logic                 perm_start;
    logic                 perm_done;
    logic                 dout_valid;
    logic                 dout_ready;
    logic                 dout_last;
    logic [4:0]           word_idx;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, in_len, out_len, din_valid, perm_done, dout_ready,
        output din_ready, absorb_en, last_bits, pad_en, pad_pos, perm_start,
               dout_valid, dout_last, word_idx, busy, done
    );

    modport slave (
        output start, in_len, out_len, din_valid, perm_done, dout_ready,
        input  din_ready, absorb_en, last_bits, pad_en, pad_pos, perm_start,
               dout_valid, dout_last, word_idx, busy, done
    );
endinterface

// File: rtl/shake_ctrl.sv
// shake_ctrl: SHAKE job sequencer metering absorb words, padding, permutations and squeeze words
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, aborts any job without a done pulse
//   bus        shake_ctrl_if.master, all job/stream/strobe signals
module shake_ctrl #(
    parameter int W          = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int RATE_WORDS = 21
) (
    input logic          clk,
    input logic          rst,
    shake_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM, SQUEEZE} state_t;

    localparam logic [LEN_WIDTH-1:0] W_LEN = LEN_WIDTH'(W);
    localparam logic [4:0]           RATE  = 5'(RATE_WORDS);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] rem_in_q, rem_in_d;
    logic [LEN_WIDTH-1:0] rem_out_q, rem_out_d;
    logic [4:0]           word_idx_q, word_idx_d;
    logic [10:0]          pad_pos_q, pad_pos_d;
    logic                 pad_pending_q, pad_pending_d;
    logic                 squeeze_next_q, squeeze_next_d;
    logic                 perm_start_q;
    logic                 done_q, done_d;

    logic [LEN_WIDTH-1:0] in_take, out_take;
    logic [4:0]           idx_inc;
    logic                 in_hs, out_hs;

    // Bits consumed/produced by the current word: min(remaining, W)
    assign in_take  = rem_in_q < W_LEN ? rem_in_q : W_LEN;
    assign out_take = rem_out_q < W_LEN ? rem_out_q : W_LEN;
    assign idx_inc  = word_idx_q + 5'd1;
    assign in_hs    = state_q == ABSORB && rem_in_q != '0 && bus.din_valid;
    assign out_hs   = state_q == SQUEEZE && bus.dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            rem_in_q       <= '0;
            rem_out_q      <= '0;
            word_idx_q     <= '0;
            pad_pos_q      <= '0;
            pad_pending_q  <= 1'b0;
            squeeze_next_q <= 1'b0;
            perm_start_q   <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rem_in_q       <= rem_in_d;
            rem_out_q      <= rem_out_d;
            word_idx_q     <= word_idx_d;
            pad_pos_q      <= pad_pos_d;
            pad_pending_q  <= pad_pending_d;
            squeeze_next_q <= squeeze_next_d;
            // request is issued only on the cycle PERM is entered
            perm_start_q   <= state_d == PERM && state_q != PERM;
            done_q         <= done_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rem_in_d       = rem_in_q;
        rem_out_d      = rem_out_q;
        word_idx_d     = word_idx_q;
        pad_pos_d      = pad_pos_q;
        pad_pending_d  = pad_pending_q;
        squeeze_next_d = squeeze_next_q;
        done_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_in_d       = bus.in_len;
                    rem_out_d      = bus.out_len;
                    word_idx_d     = '0;
                    pad_pos_d      = '0;
                    pad_pending_d  = 1'b0;
                    squeeze_next_d = 1'b0;
                    state_d        = ABSORB;
                end
            end
            ABSORB: begin
                if (rem_in_q == '0) begin
                    state_d = PAD;
                end else if (in_hs) begin
                    rem_in_d   = rem_in_q - in_take;
                    word_idx_d = idx_inc;
                    // pad_pos tracks bytes absorbed into the current block
                    pad_pos_d  = pad_pos_q + 11'(in_take >> 3);
                    if (idx_inc == RATE) begin
                        // a message ending exactly on a block boundary pads into a fresh block
                        pad_pending_d = rem_in_d == '0;
                        state_d       = PERM;
                    end else if (rem_in_d == '0) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                pad_pending_d  = 1'b0;
                squeeze_next_d = 1'b1;
                state_d        = PERM;
            end
            PERM: begin
                if (bus.perm_done) begin
                    word_idx_d = '0;
                    pad_pos_d  = '0;
                    if (pad_pending_q) begin
                        state_d = PAD;
                    end else if (squeeze_next_q && rem_out_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = squeeze_next_q ? SQUEEZE : ABSORB;
                    end
                end
            end
            SQUEEZE: begin
                if (out_hs) begin
                    rem_out_d  = rem_out_q - out_take;
                    word_idx_d = idx_inc;
                    if (rem_out_d == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (idx_inc == RATE) begin
                        state_d = PERM;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy       = state_q != IDLE;
    assign bus.din_ready  = state_q == ABSORB && rem_in_q != '0;
    assign bus.absorb_en  = in_hs;
    assign bus.last_bits  = rem_in_q == '0 ? 7'(W) : 7'(in_take);
    assign bus.pad_en     = state_q == PAD;
    assign bus.pad_pos    = pad_pos_q;
    assign bus.perm_start = perm_start_q;
    assign bus.dout_valid = state_q == SQUEEZE;
    assign bus.dout_last  = state_q == SQUEEZE && rem_out_q <= W_LEN;
    assign bus.word_idx   = word_idx_q;
    assign bus.done       = done_q;
endmodule

// File: doc/shake_ctrl.md
Name: shake_ctrl

Overview:
Top-level sequencer for the SHAKE core. It accepts a job (input length, output length), meters the input word stream into rate-sized blocks, and schedules padding and the Keccak permutation. It then meters squeezed output words. It drives the state-array datapath and permutation engine through strobes and owns all length and word-position bookkeeping.

Parameters:
W, 64, lane/word width in bits
LEN_WIDTH, 32, width of bit-length fields
RATE_WORDS, 21, rate in W-bit words (21 = SHAKE128, 17 = SHAKE256)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  job start pulse; sampled only in IDLE
in_len  in  LEN_WIDTH  message length in bits, multiple of 8
out_len  in  LEN_WIDTH  output length in bits, multiple of 8
din_valid  in  1  input word available
din_ready  out  1  controller accepts input word
absorb_en  out  1  datapath XORs din into lane word_idx (= din_valid & din_ready)
last_bits  out  7  valid bits of current input word (W when full, else remaining 8..56)
pad_en  out  1  datapath applies 0x1F at byte pad_pos and 0x80 at byte RATE_WORDS*8-1
pad_pos  out  11  byte offset of first pad byte within block
perm_start  out  1  one-cycle permutation request
perm_done  in  1  permutation finished pulse
dout_valid  out  1  squeezed lane word_idx valid on datapath output
dout_ready  in  1  consumer accepts output word
dout_last  out  1  current output word is final; valid bits = min(rem_out, W)
word_idx  out  5  current lane index within block
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse on job completion

Behaviour:
- Reset: state IDLE, rem_in=rem_out=0, word_idx=0, pad_pending=0. All outputs 0 except last_bits=W.
- IDLE: on start, latch rem_in=in_len and rem_out=out_len, set word_idx=0, go to ABSORB. Next cycle busy=1. start is ignored in all other states.
- ABSORB:
  - If rem_in=0 on entry (empty message), go to PAD; din_ready stays 0.
  - Otherwise din_ready=1. last_bits=min(rem_in,W).
  - On handshake: rem_in -= min(rem_in,W) (saturate at 0) and word_idx++.
  - After the handshake:
    - rem_in=0 and word_idx<RATE_WORDS: go to PAD.
    - rem_in=0 and word_idx=RATE_WORDS (message ends on a block boundary): set pad_pending, go to PERM.
    - rem_in>0 and word_idx=RATE_WORDS: go to PERM.
- PAD: one cycle. pad_en=1 and pad_pos = word_idx_at_end*8 + partial_bytes (0 when block was just permuted). Then clear pad_pending and go to PERM with squeeze_next set.
- PERM:
  - perm_start=1 in the first cycle only. Hold until perm_done, then set word_idx=0.
  - Exit when perm_done, in priority order:
    1. pad_pending: go to PAD.
    2. squeeze_next and rem_out=0: go to IDLE with done=1.
    3. squeeze_next: go to SQUEEZE.
    4. Otherwise: go to ABSORB.
  - perm_done outside PERM is ignored.
- SQUEEZE:
  - dout_valid=1. dout_last=(rem_out<=W).
  - On handshake: rem_out -= min(rem_out,W) and word_idx++.
  - rem_out becomes 0: go to IDLE and pulse done (same cycle as state change).
  - Else word_idx=RATE_WORDS: go to PERM (squeeze_next kept).
  - dout_valid holds and word_idx is stable while dout_ready=0.
- Latency: start to din_ready = 1 cycle; last input handshake to pad_en = 1 cycle; pad_en to perm_start = 1 cycle; perm_done to dout_valid = 1 cycle.
- Widths: length arithmetic is LEN_WIDTH unsigned with subtraction saturating at 0. word_idx never exceeds RATE_WORDS.
- rst in any state aborts the job immediately: next cycle in IDLE with reset values, and no done pulse.

Test Plan:
- Empty message: start, in_len=0, out_len=64 -> no din_ready; pad_en with pad_pos=0; one perm_start; one dout word with dout_last=1; done.
- Single partial word: in_len=72 -> 2 input handshakes, last_bits=64 then 8; pad_pos=9; one perm.
- Exact block: in_len=1344, RATE_WORDS=21 -> 21 handshakes; perm (pad_pending); pad_en with pad_pos=0; second perm; then squeeze.
- Long squeeze: out_len=1408 -> 21 output words, perm_start, 1 more word with dout_last=1, done; word_idx wraps 20->0.
- Backpressure: random din_valid/dout_ready gaps and perm_done delayed 30 cycles -> word counts, word_idx and outputs identical to the no-stall run; start pulses while busy are ignored.
- Reset mid-squeeze after 5 words -> next cycle busy=0, dout_valid=0, no done; a new job then completes normally.
